// File: rtl/match_resp_pe_pkg.sv
// rtl/match_resp_pe_pkg.sv - shared widths and length helper for the match responder PE
package match_resp_pe_pkg;

    localparam int ADDR_WIDTH      = 16;
    localparam int MATCH_LEN_WIDTH = 8;
    localparam int LAZY_MATCH_LEN  = 4;
    localparam int MATCH_PE_WIDTH  = 8;
    localparam int MAX_MATCH_LEN   = 64;
    localparam int CNT_WIDTH       = $clog2(MATCH_PE_WIDTH) + 1;

    // Adds a window count to the running length, clamped at MAX_MATCH_LEN.
    function automatic logic [MATCH_LEN_WIDTH-1:0] sat_len(
        input logic [MATCH_LEN_WIDTH-1:0] len,
        input logic [CNT_WIDTH-1:0]       cnt
    );
        logic [MATCH_LEN_WIDTH:0] sum;
        sum = {1'b0, len} + {{(MATCH_LEN_WIDTH + 1 - CNT_WIDTH){1'b0}}, cnt};
        if (sum > (MATCH_LEN_WIDTH + 1)'(MAX_MATCH_LEN)) begin
            sum = (MATCH_LEN_WIDTH + 1)'(MAX_MATCH_LEN);
        end
        return sum[MATCH_LEN_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/match_resp_pe_if.sv
// rtl/match_resp_pe_if.sv - match req/resp and window read signal bundle
interface match_resp_pe_if;
    import match_resp_pe_pkg::*;

    logic                          match_req_valid;
    logic                          match_req_ready;
    logic [ADDR_WIDTH-1:0]         match_req_head_addr;
    logic [ADDR_WIDTH-1:0]         match_req_history_addr;
    logic [LAZY_MATCH_LEN-1:0]     match_req_tag;
    logic [ADDR_WIDTH-1:0]         match_limit_addr;
    logic                          match_resp_valid;
    logic [MATCH_LEN_WIDTH-1:0]    match_resp_len;
    logic [LAZY_MATCH_LEN-1:0]     match_resp_tag;
    logic                          match_resp_ready;
    logic                          rd_req_valid;
    logic [ADDR_WIDTH-1:0]         rd_req_head_addr;
    logic [ADDR_WIDTH-1:0]         rd_req_history_addr;
    logic                          rd_req_ready;
    logic                          rd_resp_valid;
    logic [8*MATCH_PE_WIDTH-1:0]   rd_resp_head_data;
    logic [8*MATCH_PE_WIDTH-1:0]   rd_resp_history_data;

    modport slave (
        input  match_req_valid, match_req_head_addr, match_req_history_addr,
               match_req_tag, match_limit_addr, match_resp_ready,
               rd_req_ready, rd_resp_valid, rd_resp_head_data, rd_resp_history_data,
        output match_req_ready, match_resp_valid, match_resp_len, match_resp_tag,
               rd_req_valid, rd_req_head_addr, rd_req_history_addr
    );

    modport master (
        output match_req_valid, match_req_head_addr, match_req_history_addr,
               match_req_tag, match_limit_addr, match_resp_ready,
               rd_req_ready, rd_resp_valid, rd_resp_head_data, rd_resp_history_data,
        input  match_req_ready, match_resp_valid, match_resp_len, match_resp_tag,
               rd_req_valid, rd_req_head_addr, rd_req_history_addr
    );

endinterface

// File: rtl/match_resp_pe_window_cmp.sv
// rtl/match_resp_pe_window_cmp.sv - count of leading equal bytes in one window pair
module match_window_cmp
    import match_resp_pe_pkg::*;
(
    input  logic [8*MATCH_PE_WIDTH-1:0] head_data_i,
    input  logic [8*MATCH_PE_WIDTH-1:0] history_data_i,
    input  logic [ADDR_WIDTH-1:0]       remain_i,
    output logic [CNT_WIDTH-1:0]        cnt_o
);

    logic [MATCH_PE_WIDTH-1:0] eq;

    // Bytes at or beyond the limit are forced unequal so they can never extend a match.
    always_comb begin
        eq = '0;
        for (int i = 0; i < MATCH_PE_WIDTH; i++) begin
            eq[i] = (head_data_i[8*i +: 8] == history_data_i[8*i +: 8]) &&
                    (ADDR_WIDTH'(i) < remain_i);
        end
    end

    always_comb begin
        cnt_o = CNT_WIDTH'(MATCH_PE_WIDTH);
        for (int i = MATCH_PE_WIDTH - 1; i >= 0; i--) begin
            if (!eq[i]) begin
                cnt_o = CNT_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/match_resp_pe.sv
// rtl/match_resp_pe.sv - responder PE: extends a match window by window and returns the length
module match_resp_pe
    import match_resp_pe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    match_resp_pe_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      head_q, head_d;
    logic [ADDR_WIDTH-1:0]      hist_q, hist_d;
    logic [ADDR_WIDTH-1:0]      remain_q, remain_d;
    logic [MATCH_LEN_WIDTH-1:0] len_q, len_d;
    logic [LAZY_MATCH_LEN-1:0]  tag_q, tag_d;

    logic [CNT_WIDTH-1:0]       cnt;
    logic [MATCH_LEN_WIDTH-1:0] nlen;

    match_window_cmp u_cmp (
        .head_data_i    (bus.rd_resp_head_data),
        .history_data_i (bus.rd_resp_history_data),
        .remain_i       (remain_q),
        .cnt_o          (cnt)
    );

    assign nlen = sat_len(len_q, cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            head_q   <= '0;
            hist_q   <= '0;
            remain_q <= '0;
            len_q    <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            hist_q   <= hist_d;
            remain_q <= remain_d;
            len_q    <= len_d;
            tag_q    <= tag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        hist_d   = hist_q;
        remain_d = remain_q;
        len_d    = len_q;
        tag_d    = tag_q;

        bus.match_req_ready  = 1'b0;
        bus.match_resp_valid = 1'b0;
        bus.rd_req_valid     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                bus.match_req_ready = 1'b1;
                if (bus.match_req_valid) begin
                    head_d   = bus.match_req_head_addr;
                    hist_d   = bus.match_req_history_addr;
                    tag_d    = bus.match_req_tag;
                    len_d    = '0;
                    remain_d = bus.match_limit_addr - bus.match_req_head_addr;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                bus.rd_req_valid = 1'b1;
                if (bus.rd_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.rd_resp_valid) begin
                    len_d    = nlen;
                    head_d   = head_q + ADDR_WIDTH'(MATCH_PE_WIDTH);
                    hist_d   = hist_q + ADDR_WIDTH'(MATCH_PE_WIDTH);
                    remain_d = (remain_q > ADDR_WIDTH'(MATCH_PE_WIDTH)) ?
                               remain_q - ADDR_WIDTH'(MATCH_PE_WIDTH) : '0;
                    // Stop on a short window, saturation, or when the limit falls inside this window.
                    if ((cnt < CNT_WIDTH'(MATCH_PE_WIDTH)) ||
                        (nlen == MATCH_LEN_WIDTH'(MAX_MATCH_LEN)) ||
                        (remain_q <= ADDR_WIDTH'(MATCH_PE_WIDTH))) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_RESP: begin
                bus.match_resp_valid = 1'b1;
                if (bus.match_resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.match_resp_len      = len_q;
    assign bus.match_resp_tag      = tag_q;
    assign bus.rd_req_head_addr    = head_q;
    assign bus.rd_req_history_addr = hist_q;

endmodule

// File: tb/tb_match_resp_pe.sv
// tb/tb_match_resp_pe.sv - directed self-checking bench for match_resp_pe
module tb_match_resp_pe;
    import match_resp_pe_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_head_log[$];
    logic [15:0] rd_hist_log[$];

    match_resp_pe_if bus ();

    match_resp_pe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle window buffer model; not reset so stale data can follow a reset.
    always @(posedge clk) begin
        bus.rd_resp_valid <= bus.rd_req_valid && bus.rd_req_ready;
        if (bus.rd_req_valid && bus.rd_req_ready) begin
            rd_head_log.push_back(bus.rd_req_head_addr);
            rd_hist_log.push_back(bus.rd_req_history_addr);
            for (int i = 0; i < MATCH_PE_WIDTH; i++) begin
                bus.rd_resp_head_data[8*i +: 8]    <= mem[16'(bus.rd_req_head_addr + 16'(i))];
                bus.rd_resp_history_data[8*i +: 8] <= mem[16'(bus.rd_req_history_addr + 16'(i))];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setup_match(input logic [15:0] head, input logic [15:0] hist, input int n);
        for (int i = 0; i < n; i++) begin
            mem[16'(head + 16'(i))] = mem[16'(hist + 16'(i))];
        end
        mem[16'(head + 16'(n))] = mem[16'(hist + 16'(n))] ^ 8'hFF;
    endtask

    task automatic run_job(input string name, input logic [15:0] head, input logic [15:0] hist,
                           input logic [3:0] tag, input logic [15:0] limit, input int hold,
                           input logic [7:0] exp_len, input int exp_reads);
        int   budget;
        logic seen;
        rd_head_log.delete();
        rd_hist_log.delete();
        bus.match_req_head_addr    = head;
        bus.match_req_history_addr = hist;
        bus.match_req_tag          = tag;
        bus.match_limit_addr       = limit;
        bus.match_req_valid        = 1'b1;
        check({name, "_req_ready"}, 32'(bus.match_req_ready), 32'd1);
        tick();
        bus.match_req_valid = 1'b0;
        seen   = 1'b0;
        budget = 0;
        while (!seen && budget < 500) begin
            if (bus.match_resp_valid) seen = 1'b1;
            else begin
                tick();
                budget++;
            end
        end
        check({name, "_resp_seen"}, 32'(seen), 32'd1);
        for (int k = 0; k < hold; k++) begin
            check({name, "_hold_valid"}, 32'(bus.match_resp_valid), 32'd1);
            check({name, "_hold_len"}, 32'(bus.match_resp_len), 32'(exp_len));
            check({name, "_hold_req_ready"}, 32'(bus.match_req_ready), 32'd0);
            tick();
        end
        check({name, "_len"}, 32'(bus.match_resp_len), 32'(exp_len));
        check({name, "_tag"}, 32'(bus.match_resp_tag), 32'(tag));
        check({name, "_reads"}, 32'(rd_head_log.size()), 32'(exp_reads));
        bus.match_resp_ready = 1'b1;
        tick();
        bus.match_resp_ready = 1'b0;
        check({name, "_idle_after"}, 32'(bus.match_req_ready), 32'd1);
        check({name, "_resp_drop"}, 32'(bus.match_resp_valid), 32'd0);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        bus.match_req_valid        = 1'b0;
        bus.match_req_head_addr    = '0;
        bus.match_req_history_addr = '0;
        bus.match_req_tag          = '0;
        bus.match_limit_addr       = '0;
        bus.match_resp_ready       = 1'b0;
        bus.rd_req_ready           = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        check("rst_req_ready", 32'(bus.match_req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.match_resp_valid), 32'd0);
        check("rst_rd_req_valid", 32'(bus.rd_req_valid), 32'd0);
        check("rst_resp_len", 32'(bus.match_resp_len), 32'd0);
        check("rst_rd_head_addr", 32'(bus.rd_req_head_addr), 32'd0);
        rst = 1'b0;
        tick();

        setup_match(16'h2000, 16'h1000, 20);
        run_job("t1_len20", 16'h2000, 16'h1000, 4'b0100, 16'h8000, 0, 8'd20, 3);

        setup_match(16'h2100, 16'h1100, 0);
        run_job("t2_first_diff", 16'h2100, 16'h1100, 4'b0001, 16'h8000, 0, 8'd0, 1);

        setup_match(16'h3000, 16'h1200, 200);
        run_job("t3_saturate", 16'h3000, 16'h1200, 4'b0010, 16'h8000, 0, 8'd64, 8);

        setup_match(16'h4000, 16'h1400, 40);
        run_job("t4_limit13", 16'h4000, 16'h1400, 4'b1000, 16'h400D, 0, 8'd13, 2);
        run_job("t4_limit0", 16'h4000, 16'h1400, 4'b0100, 16'h4000, 0, 8'd0, 1);

        setup_match(16'hFFFC, 16'h0100, 12);
        run_job("t5_wrap", 16'hFFFC, 16'h0100, 4'b0001, 16'h1000, 0, 8'd12, 2);
        if (rd_head_log.size() == 2) begin
            check("t5_second_head_addr", 32'(rd_head_log[1]), 32'h0004);
            check("t5_second_hist_addr", 32'(rd_hist_log[1]), 32'h0108);
        end else begin
            check("t5_log_size", 32'(rd_head_log.size()), 32'd2);
        end

        setup_match(16'h5000, 16'h1600, 20);
        run_job("t6_backpressure", 16'h5000, 16'h1600, 4'b1000, 16'h8000, 5, 8'd20, 3);

        // Reset while waiting on window data that is valid in the same cycle.
        setup_match(16'h6000, 16'h1800, 30);
        bus.match_req_head_addr    = 16'h6000;
        bus.match_req_history_addr = 16'h1800;
        bus.match_req_tag          = 4'b0010;
        bus.match_limit_addr       = 16'h8000;
        bus.match_req_valid        = 1'b1;
        tick();
        bus.match_req_valid = 1'b0;
        check("t6r_rd_req_valid", 32'(bus.rd_req_valid), 32'd1);
        tick();
        check("t6r_in_wait", 32'(bus.rd_req_valid), 32'd0);
        check("t6r_stale_data_valid", 32'(bus.rd_resp_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6r_idle_req_ready", 32'(bus.match_req_ready), 32'd1);
        check("t6r_no_resp", 32'(bus.match_resp_valid), 32'd0);
        check("t6r_no_rd_req", 32'(bus.rd_req_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6r_stays_idle", 32'(bus.match_resp_valid), 32'd0);
        end

        setup_match(16'h7000, 16'h1A00, 5);
        run_job("t7_after_reset", 16'h7000, 16'h1A00, 4'b0001, 16'h8000, 0, 8'd5, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
